// File: rtl/div_pkg.sv
// div_pkg: state encoding, default ratio and high-time window shared by the divider and its monitor
package div_pkg;
    typedef enum logic {IDLE, MEASURE} state_t;
    localparam int DIV_DEFAULT = 9;
    function automatic int hi_min(input int div);
        return div / 2;
    endfunction
    function automatic int hi_max(input int div);
        return (div + 1) / 2;
    endfunction
endpackage

// File: rtl/div_edge_det.sv
// div_edge_det: registers the previous level of a clk-domain signal and flags its edges
module div_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic s_prev;
    always_ff @(posedge clk) s_prev <= !rstn ? 1'b0 : d;
    assign rise = d & ~s_prev;
    assign fall = ~d & s_prev;
endmodule

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures period and high time of a divided clock and checks them against DIV
module div_clk_monitor import div_pkg::*; #(
    parameter int DIV     = DIV_DEFAULT,
    parameter int CW      = 8,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 18
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clk_in,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_cnt,
    output logic          meas_valid,
    output logic          period_err,
    output logic          timeout,
    output logic          lock,
    output logic [7:0]    err_cnt
);
    localparam logic [CW-1:0] DIV_C  = CW'(DIV);
    localparam logic [CW-1:0] TO_C   = CW'(TIMEOUT);
    localparam logic [CW-1:0] HI_MIN = CW'(hi_min(DIV));
    localparam logic [CW-1:0] HI_MAX = CW'(hi_max(DIV));
    localparam logic [CW-1:0] HC_SAT = '1;
    localparam logic [3:0]    LOCK_C = 4'(LOCK_N);
    state_t        state, state_nx;
    logic          rise, measure, expire, good, bad;
    logic [CW-1:0] per_cnt, hc;
    logic [3:0]    run, run_nx;
    div_edge_det u_edge (
        .clk  (clk),
        .rstn (rstn),
        .d    (clk_in),
        .rise (rise),
        .fall ()
    );
    assign good   = per_cnt == DIV_C && hc >= HI_MIN && hc <= HI_MAX;
    assign bad    = measure & ~good;
    assign run_nx = run == LOCK_C ? run : run + 4'd1;
    // a rise on the timeout cycle is still a measurement, so it masks the timeout
    always_comb begin
        measure  = state == MEASURE && rise;
        expire   = state == MEASURE && !rise && per_cnt == TO_C;
        state_nx = state == IDLE ? (rise ? MEASURE : IDLE) : (expire ? IDLE : MEASURE);
    end
    always_ff @(posedge clk) state <= !rstn ? IDLE : state_nx;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            per_cnt    <= '0;
            hc         <= '0;
            period     <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            period_err <= 1'b0;
            timeout    <= 1'b0;
            lock       <= 1'b0;
            run        <= '0;
            err_cnt    <= '0;
        end else begin
            per_cnt    <= rise ? CW'(1) : (per_cnt == TO_C ? per_cnt : per_cnt + CW'(1));
            hc         <= rise ? CW'(1) : (hc == HC_SAT ? hc : hc + CW'(clk_in));
            meas_valid <= measure;
            period_err <= bad;
            timeout    <= expire;
            if (measure) begin
                period   <= per_cnt;
                high_cnt <= hc;
            end
            if (bad || expire) begin
                run  <= '0;
                lock <= 1'b0;
            end else if (measure) begin
                run <= run_nx;
                if (run_nx == LOCK_C) lock <= 1'b1;
            end
            if ((bad || expire) && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: directed streams with a scoreboard of expected measurements
module tb_div_clk_monitor;
    localparam int DIV = 9, CW = 8, LOCK_N = 4, TIMEOUT = 18;
    logic          clk = 1'b0, rstn = 1'b0, clk_in = 1'b0;
    logic [CW-1:0] period, high_cnt;
    logic          meas_valid, period_err, timeout, lock;
    logic [7:0]    err_cnt;
    int            checks = 0, errors = 0;
    typedef struct {int p; int h; bit e; bit l; int c;} exp_t;
    exp_t q[$];
    bit   armed = 0, m_lock = 0;
    int   prev_p = 0, prev_h = 0, run = 0, m_ecnt = 0;

    div_clk_monitor #(.DIV(DIV), .CW(CW), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clk_in     (clk_in),
        .period     (period),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .period_err (period_err),
        .timeout    (timeout),
        .lock       (lock),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (meas_valid === 1'b1) begin
            if (q.size() == 0) chk("unexpected_meas", 1, 0);
            else begin
                e = q.pop_front();
                chk("period", period, e.p);
                chk("high_cnt", high_cnt, e.h);
                chk("period_err", period_err, e.e);
                chk("lock", lock, e.l);
                chk("err_cnt", err_cnt, e.c);
                chk("meas_timeout", timeout, 0);
            end
        end
    end

    task automatic cyc(input logic v);
        clk_in = v;
        @(posedge clk);
        #1;
    endtask

    // one divided-clock period: h cycles high then p-h low; its rise closes the previous period
    task automatic send(input int p, input int h);
        bit good, was;
        was = armed;
        if (armed) begin
            good = prev_p == DIV && prev_h >= 4 && prev_h <= 5;
            if (good) begin
                run = run < LOCK_N ? run + 1 : run;
                if (run == LOCK_N) m_lock = 1;
            end else begin
                run = 0;
                m_lock = 0;
                m_ecnt = m_ecnt < 255 ? m_ecnt + 1 : 255;
            end
            q.push_back('{prev_p, prev_h, !good, m_lock, m_ecnt});
        end
        for (int i = 0; i < p; i++) begin
            cyc(i < h);
            if (i == 0 && !was) chk("unarmed_rise_no_meas", meas_valid, 0);
        end
        prev_p = p;
        prev_h = h;
        armed = 1;
    endtask

    initial begin
        int n;
        rstn = 0;
        clk_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {period, high_cnt, meas_valid, period_err, timeout, lock, err_cnt}, 0);
        rstn = 1;
        cyc(0);
        cyc(0);
        repeat (6) send(9, 4);
        chk("lock_ideal", lock, 1);
        send(8, 4);
        repeat (5) send(9, 4);
        chk("relock", lock, 1);
        chk("err_after_short", err_cnt, 1);
        send(9, 3);
        send(9, 6);
        send(9, 5);
        send(9, 4);
        send(9, 4);
        chk("err_after_high", err_cnt, 3);
        repeat (4) send(9, 4);
        chk("lock_before_stuck", lock, 1);
        n = 0;
        while (timeout !== 1'b1 && n < 40) begin
            cyc(0);
            n++;
        end
        chk("timeout_edge", 8 + n, 18);
        armed = 0;
        run = 0;
        m_lock = 0;
        m_ecnt++;
        chk("timeout_lock", lock, 0);
        chk("timeout_err_cnt", err_cnt, m_ecnt);
        cyc(0);
        chk("timeout_one_pulse", timeout, 0);
        repeat (6) send(9, 4);
        chk("lock_after_timeout", lock, 1);
        rstn = 0;
        cyc(0);
        chk("midrst_outputs", {period, high_cnt, meas_valid, period_err, timeout, lock, err_cnt}, 0);
        rstn = 1;
        armed = 0;
        run = 0;
        m_lock = 0;
        m_ecnt = 0;
        cyc(0);
        repeat (6) send(9, 4);
        chk("lock_after_rst", lock, 1);
        chk("err_after_rst", err_cnt, 0);
        repeat (302) send(7, 3);
        send(9, 4);
        chk("err_saturated", err_cnt, 255);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
